// File: rtl/psum_drain_pkg.sv
// ============================================================================
//  Module  : psum_drain_pkg
//  Brief   : Shared constants for the psum drain: FSM state codes, pool-size
//            encoding and a helper that decodes the pool field to a group size.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package psum_drain_pkg;

  // FSM state codes
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] READ = 3'd1;
  localparam logic [2:0] CAPT = 3'd2;
  localparam logic [2:0] OUT  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  // Pool field encoding: group size G = field + 1
  localparam logic [1:0] POOL_NONE = 2'd0;
  localparam logic [1:0] POOL_2    = 2'd1;
  localparam logic [1:0] POOL_3    = 2'd2;
  localparam logic [1:0] POOL_4    = 2'd3;

  // Number of samples folded into one output word
  function automatic logic [2:0] group_size(input logic [1:0] pool);
    case (pool)
      POOL_NONE: group_size = 3'd1;
      POOL_2:    group_size = 3'd2;
      POOL_3:    group_size = 3'd3;
      POOL_4:    group_size = 3'd4;
      default:   group_size = 3'd1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/psum_drain_pool_acc.sv
// ============================================================================
//  Module  : pool_acc
//  Brief   : One bank's ReLU stage and signed running-max accumulator.
//            load alone folds the sample in with max(); load together with
//            clear replaces the accumulator (first sample of a group);
//            clear alone zeroes it.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pool_acc #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_clear,
  input  logic                         i_load,
  input  logic signed [DATA_WIDTH-1:0] i_sample,
  input  logic                         i_relu,
  output logic signed [DATA_WIDTH-1:0] o_acc
);

  logic signed [DATA_WIDTH-1:0] w_val;
  logic signed [DATA_WIDTH-1:0] r_acc;

  // ReLU: negative samples become zero when enabled
  always_comb begin
    w_val = i_sample;
    if (i_relu && i_sample[DATA_WIDTH-1]) w_val = '0;
  end

  // Running max; the first sample of a group overwrites the old result
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else if (i_load) begin
      if (i_clear || (w_val > r_acc)) r_acc <= w_val;
    end else if (i_clear) begin
      r_acc <= '0;
    end
  end

  assign o_acc = r_acc;

endmodule

`default_nettype wire

// File: rtl/psum_drain.sv
// ============================================================================
//  Module  : psum_drain
//  Brief   : Reads finished partial sums from both pmem banks, applies optional
//            ReLU and 1-D max-pooling, and streams {bank1,bank0} result pairs
//            over valid/ready. Owns both pmem read ports while busy.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module psum_drain
  import psum_drain_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int PMEM_ADDR_WIDTH = 8,
  parameter int CNT_WIDTH       = PMEM_ADDR_WIDTH + 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic [PMEM_ADDR_WIDTH-1:0]   i_base_addr0,
  input  logic [PMEM_ADDR_WIDTH-1:0]   i_base_addr1,
  input  logic [CNT_WIDTH-1:0]         i_count,
  input  logic                         i_relu,
  input  logic [1:0]                   i_pool,
  output logic                         o_pmem_rd_en,
  output logic [PMEM_ADDR_WIDTH-1:0]   o_pmem_rd_addr0,
  output logic [PMEM_ADDR_WIDTH-1:0]   o_pmem_rd_addr1,
  input  logic signed [DATA_WIDTH-1:0] i_pmem_rd_data0,
  input  logic signed [DATA_WIDTH-1:0] i_pmem_rd_data1,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [2*DATA_WIDTH-1:0]      o_data,
  output logic                         o_busy,
  output logic                         o_done
);

  logic [2:0]                 r_state;
  logic [PMEM_ADDR_WIDTH-1:0] r_base0;
  logic [PMEM_ADDR_WIDTH-1:0] r_base1;
  logic [CNT_WIDTH-1:0]       r_count;
  logic                       r_relu;
  logic [1:0]                 r_pool;
  logic [CNT_WIDTH-1:0]       r_idx;
  logic [2:0]                 r_grp;

  logic [2:0]                 w_gsize;
  logic [2:0]                 w_grp_next;
  logic                       w_last;
  logic                       w_accept;
  logic                       w_capt;
  logic                       w_acc_clear;
  logic signed [DATA_WIDTH-1:0] w_acc0;
  logic signed [DATA_WIDTH-1:0] w_acc1;

  assign w_gsize     = group_size(r_pool);
  assign w_grp_next  = r_grp + 3'd1;
  // idx has already advanced past the word being captured, so idx==count
  // means the last word of the drain is in flight
  assign w_last      = (r_idx == r_count);
  assign w_accept    = (r_state == IDLE) && i_start;
  assign w_capt      = (r_state == CAPT);
  assign w_acc_clear = w_accept || (w_capt && (r_grp == 3'd0));

  // Drain sequencing, config latch and index/group counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_base0 <= '0;
      r_base1 <= '0;
      r_count <= '0;
      r_relu  <= 1'b0;
      r_pool  <= POOL_NONE;
      r_idx   <= '0;
      r_grp   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_base0 <= i_base_addr0;
            r_base1 <= i_base_addr1;
            r_count <= i_count;
            r_relu  <= i_relu;
            r_pool  <= i_pool;
            r_idx   <= '0;
            r_grp   <= '0;
            r_state <= (i_count == '0) ? DONE : READ;
          end
        end
        READ: begin
          r_idx   <= r_idx + CNT_WIDTH'(1);
          r_state <= CAPT;
        end
        CAPT: begin
          if ((w_grp_next == w_gsize) || w_last) begin
            r_grp   <= '0;
            r_state <= OUT;
          end else begin
            r_grp   <= w_grp_next;
            r_state <= READ;
          end
        end
        OUT: begin
          if (i_ready) r_state <= w_last ? DONE : READ;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  pool_acc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_acc0 (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (w_acc_clear),
    .i_load   (w_capt),
    .i_sample (i_pmem_rd_data0),
    .i_relu   (r_relu),
    .o_acc    (w_acc0)
  );

  pool_acc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_acc1 (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (w_acc_clear),
    .i_load   (w_capt),
    .i_sample (i_pmem_rd_data1),
    .i_relu   (r_relu),
    .o_acc    (w_acc1)
  );

  // Outputs decode straight from registered state; addresses and data are
  // forced to zero outside their qualifying state
  always_comb begin
    o_pmem_rd_en    = (r_state == READ);
    o_pmem_rd_addr0 = '0;
    o_pmem_rd_addr1 = '0;
    if (o_pmem_rd_en) begin
      o_pmem_rd_addr0 = r_base0 + r_idx[PMEM_ADDR_WIDTH-1:0];
      o_pmem_rd_addr1 = r_base1 + r_idx[PMEM_ADDR_WIDTH-1:0];
    end
    o_valid = (r_state == OUT);
    o_data  = o_valid ? {w_acc1, w_acc0} : '0;
    o_busy  = (r_state != IDLE);
    o_done  = (r_state == DONE);
  end

endmodule

`default_nettype wire

// File: tb/tb_psum_drain.sv
// ============================================================================
//  Module  : tb_psum_drain
//  Brief   : Self-checking bench for psum_drain with a registered pmem model
//            and queue scoreboards for output words and read addresses.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_psum_drain;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int CW = AW + 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [AW-1:0]        base0, base1;
  logic [CW-1:0]        count;
  logic                 relu;
  logic [1:0]           pool;
  logic                 rd_en;
  logic [AW-1:0]        addr0, addr1;
  logic signed [DW-1:0] rd_data0, rd_data1;
  logic                 valid;
  logic                 ready;
  logic [2*DW-1:0]      data;
  logic                 busy;
  logic                 done;

  logic signed [DW-1:0] mem0 [0:255];
  logic signed [DW-1:0] mem1 [0:255];

  logic [2*DW-1:0] exp_q[$];
  logic [2*AW-1:0] addr_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  int n_out = 0;
  int n_rd  = 0;
  int first_valid_rel = -1;
  int done_rel = -1;

  always #5 clk = ~clk;

  psum_drain #(
    .DATA_WIDTH      (DW),
    .PMEM_ADDR_WIDTH (AW),
    .CNT_WIDTH       (CW)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_start         (start),
    .i_base_addr0    (base0),
    .i_base_addr1    (base1),
    .i_count         (count),
    .i_relu          (relu),
    .i_pool          (pool),
    .o_pmem_rd_en    (rd_en),
    .o_pmem_rd_addr0 (addr0),
    .o_pmem_rd_addr1 (addr1),
    .i_pmem_rd_data0 (rd_data0),
    .i_pmem_rd_data1 (rd_data1),
    .o_valid         (valid),
    .i_ready         (ready),
    .o_data          (data),
    .o_busy          (busy),
    .o_done          (done)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // pmem: data is valid the cycle after the strobe
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data0 <= mem0[addr0];
      rd_data1 <= mem1[addr1];
    end
  end

  // Scoreboard side: pop expected words / addresses as the DUT produces them
  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      if (!rd_en && (addr0 != '0 || addr1 != '0)) begin
        bad++;
        $display("FAIL addr_idle: got %0d/%0d want 0/0", addr0, addr1);
      end
      if (rd_en) begin
        n_rd++;
        total++;
        if (addr_q.size() == 0) begin
          bad++;
          $display("FAIL rd_unexpected: got addr %0d/%0d want no read", addr0, addr1);
        end else begin
          logic [2*AW-1:0] ea;
          ea = addr_q.pop_front();
          if ({addr1, addr0} !== ea) begin
            bad++;
            $display("FAIL rd_addr: got %0d/%0d want %0d/%0d", addr0, addr1, ea[AW-1:0], ea[2*AW-1:AW]);
          end
        end
      end
      if (valid && first_valid_rel < 0) first_valid_rel = cyc - t0 + 1;
      if (valid && ready) begin
        n_out++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL out_unexpected: got %h want no output", data);
        end else begin
          logic [2*DW-1:0] e;
          e = exp_q.pop_front();
          if (data !== e) begin
            bad++;
            $display("FAIL out_data: got %h want %h", data, e);
          end
        end
      end
    end
  end

  // Reference: ReLU then max over groups of G, partial last group allowed
  task automatic push_model(input logic [AW-1:0] b0, input logic [AW-1:0] b1,
                            input int c, input logic r, input logic [1:0] p);
    int g;
    logic signed [DW-1:0] s0, s1, a0, a1;
    g = int'(p) + 1;
    a0 = '0;
    a1 = '0;
    for (int i = 0; i < c; i += g) begin
      for (int j = 0; j < g && (i + j) < c; j++) begin
        s0 = mem0[8'(int'(b0) + i + j)];
        s1 = mem1[8'(int'(b1) + i + j)];
        if (r && s0 < 0) s0 = 0;
        if (r && s1 < 0) s1 = 0;
        if (j == 0 || s0 > a0) a0 = s0;
        if (j == 0 || s1 > a1) a1 = s1;
      end
      exp_q.push_back({a1, a0});
    end
    for (int i = 0; i < c; i++) addr_q.push_back({8'(int'(b1) + i), 8'(int'(b0) + i)});
  endtask

  // Start a drain; on return the start edge (edge 0) has just passed
  task automatic kick(input logic [AW-1:0] b0, input logic [AW-1:0] b1,
                      input int c, input logic r, input logic [1:0] p);
    push_model(b0, b1, c, r, p);
    n_out = 0;
    n_rd = 0;
    first_valid_rel = -1;
    done_rel = -1;
    @(posedge clk);
    #1;
    base0 = b0; base1 = b1; count = CW'(c); relu = r; pool = p; start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    bit seen;
    seen = 0;
    for (int k = 0; k < limit && !seen; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        done_rel = cyc - t0 + 1;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL done_timeout: got no o_done want o_done within %0d cycles", limit);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; ready = 1'b1;
    base0 = '0; base1 = '0; count = '0; relu = 1'b0; pool = 2'd0;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if ({valid, rd_en, busy, done} !== 4'b0) begin
      bad++;
      $display("FAIL reset_ctl: got v=%b rd=%b busy=%b done=%b want all 0", valid, rd_en, busy, done);
    end
    total++;
    if ({data, addr0, addr1} !== '0) begin
      bad++;
      $display("FAIL reset_bus: got data=%h a0=%0d a1=%0d want 0", data, addr0, addr1);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_g1();
    mem0[0] = 8'sd5;    mem0[1] = -8'sd3; mem0[2] = 8'sd127;
    mem1[16] = -8'sd128; mem1[17] = 8'sd0; mem1[18] = 8'sd1;
    for (int r = 0; r < 2; r++) begin
      kick(8'd0, 8'd16, 3, r[0], 2'd0);
      wait_done(40);
      total++;
      if (first_valid_rel != 3) begin
        bad++;
        $display("FAIL g1_first_valid: got cycle %0d want 3", first_valid_rel);
      end
      total++;
      if (done_rel != 10) begin
        bad++;
        $display("FAIL g1_done_cycle: got cycle %0d want 10", done_rel);
      end
      total++;
      if (n_out != 3 || exp_q.size() != 0) begin
        bad++;
        $display("FAIL g1_count: got %0d outputs (%0d left) want 3 (0 left)", n_out, exp_q.size());
      end
    end
  endtask

  task automatic test_pool();
    mem0[32] = 8'sd1; mem0[33] = 8'sd4; mem0[34] = -8'sd2; mem0[35] = -8'sd7; mem0[36] = 8'sd9;
    for (int i = 48; i < 53; i++) mem1[i] = -8'sd1;
    kick(8'd32, 8'd48, 5, 1'b0, 2'd1);
    wait_done(60);
    total++;
    if (done_rel != 14) begin
      bad++;
      $display("FAIL pool2_done_cycle: got cycle %0d want 14", done_rel);
    end
    total++;
    if (n_out != 3 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL pool2_count: got %0d outputs (%0d left) want 3 (0 left)", n_out, exp_q.size());
    end
    // G=3 with ReLU over random data, partial last group of one
    for (int i = 64; i < 71; i++) begin
      mem0[i] = DW'($urandom);
      mem1[i + 64] = DW'($urandom);
    end
    kick(8'd64, 8'd128, 7, 1'b1, 2'd2);
    wait_done(80);
    total++;
    if (n_out != 3 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL pool3_count: got %0d outputs (%0d left) want 3 (0 left)", n_out, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic [2*DW-1:0] held;
    bit seen;
    ready = 1'b0;
    kick(8'd0, 8'd16, 3, 1'b0, 2'd0);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (valid) seen = 1;
    end
    held = data;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL bp_valid: got no o_valid want o_valid");
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (valid !== 1'b1 || data !== held || rd_en !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold: got v=%b data=%h rd=%b want v=1 data=%h rd=0", valid, data, rd_en, held);
      end
    end
    @(posedge clk);
    #1;
    ready = 1'b1;
    wait_done(40);
    total++;
    if (n_out != 3 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL bp_count: got %0d outputs (%0d left) want 3 (0 left)", n_out, exp_q.size());
    end
  endtask

  task automatic test_count0();
    kick(8'd5, 8'd6, 0, 1'b0, 2'd0);
    wait_done(10);
    total++;
    if (done_rel != 1) begin
      bad++;
      $display("FAIL c0_done_cycle: got cycle %0d want 1", done_rel);
    end
    total++;
    if (n_out != 0 || n_rd != 0) begin
      bad++;
      $display("FAIL c0_activity: got %0d outputs %0d reads want 0 0", n_out, n_rd);
    end
    // Restart while busy must be ignored
    kick(8'd0, 8'd16, 3, 1'b0, 2'd0);
    @(posedge clk);
    #1;
    start = 1'b1; count = CW'(1); base0 = 8'd100; pool = 2'd3; relu = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(40);
    total++;
    if (done_rel != 10 || n_out != 3 || n_rd != 3) begin
      bad++;
      $display("FAIL busy_start: got done=%0d out=%0d rd=%0d want 10 3 3", done_rel, n_out, n_rd);
    end
  endtask

  task automatic test_wrap_reset();
    bit hit;
    int reads;
    mem0[254] = 8'sd10; mem0[255] = -8'sd20; mem0[0] = 8'sd30; mem0[1] = -8'sd40;
    mem1[11] = -8'sd50; mem1[12] = -8'sd60; mem1[13] = -8'sd5; mem1[14] = -8'sd70;
    kick(8'd254, 8'd11, 4, 1'b0, 2'd0);
    hit = 0;
    reads = (rd_en) ? 1 : 0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(negedge clk);
      if (rd_en) begin
        reads++;
        if (reads == 2) hit = 1;
      end
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (!hit || {valid, rd_en, busy, done} !== 4'b0 || {data, addr0, addr1} !== '0) begin
      bad++;
      $display("FAIL mid_reset: got hit=%b v=%b rd=%b busy=%b done=%b data=%h want all 0",
               hit, valid, rd_en, busy, done, data);
    end
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle: got busy=%b want 0", busy);
    end
    kick(8'd254, 8'd11, 4, 1'b0, 2'd3);
    wait_done(40);
    total++;
    if (done_rel != 10 || n_out != 1 || n_rd != 4 || addr_q.size() != 0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL wrap_run: got done=%0d out=%0d rd=%0d want 10 1 4", done_rel, n_out, n_rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end
    test_reset();
    test_g1();
    test_pool();
    test_backpressure();
    test_count0();
    test_wrap_reset();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
